// File: rtl/ex_mem_wb_pipe_if.sv
// ex_mem_wb_pipe_if: EX/MEM/WB pipeline bus (EX inputs, dmem response, MEM/WB outputs, stall)
interface ex_mem_wb_pipe_if #(parameter int DATA_WIDTH = 32);
  logic                  ex_valid;
  logic                  ex_regWrite;
  logic                  ex_memRead;
  logic                  ex_memWrite;
  logic [2:0]            ex_funct3;
  logic [4:0]            ex_rd;
  logic [DATA_WIDTH-1:0] ex_alu_result;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ready;
  logic                  mem_regWrite;
  logic [4:0]            mem_rd;
  logic [DATA_WIDTH-1:0] mem_alu_result;
  logic                  mem_memRead;
  logic                  mem_memWrite;
  logic [2:0]            mem_funct3;
  logic [DATA_WIDTH-1:0] mem_store_data;
  logic                  wb_regWrite;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  pipe_stall;
  modport master (
    output ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_funct3, ex_rd,
           ex_alu_result, ex_store_data, dmem_rdata, dmem_ready,
    input  mem_regWrite, mem_rd, mem_alu_result, mem_memRead, mem_memWrite,
           mem_funct3, mem_store_data, wb_regWrite, wb_rd, wb_data, pipe_stall
  );
  modport slave (
    input  ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_funct3, ex_rd,
           ex_alu_result, ex_store_data, dmem_rdata, dmem_ready,
    output mem_regWrite, mem_rd, mem_alu_result, mem_memRead, mem_memWrite,
           mem_funct3, mem_store_data, wb_regWrite, wb_rd, wb_data, pipe_stall
  );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB registers with load alignment/extension and dmem-wait stall
module ex_mem_wb_pipe #(parameter int DATA_WIDTH = 32) (
  input logic             clk,
  input logic             rst,
  ex_mem_wb_pipe_if.slave bus
);
  logic                  mem_valid, mem_reg_write_q, mem_read_q, mem_write_q;
  logic [2:0]            mem_funct3_q;
  logic [4:0]            mem_rd_q;
  logic [DATA_WIDTH-1:0] mem_alu_q, mem_store_q;
  logic                  wb_valid, wb_reg_write_q;
  logic [4:0]            wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q, byte_sh, half_sh, load_data;
  logic                  stall;
  assign stall = mem_valid & (mem_read_q | mem_write_q) & ~bus.dmem_ready;
  // a[0] is deliberately dropped for halfwords: misaligned loads are not trapped
  always_comb begin
    byte_sh = bus.dmem_rdata >> {mem_alu_q[1:0], 3'b000};
    half_sh = bus.dmem_rdata >> {mem_alu_q[1], 4'b0000};
    load_data = mem_funct3_q == 3'b000 ? {{(DATA_WIDTH-8){byte_sh[7]}}, byte_sh[7:0]}
              : mem_funct3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_sh[7:0]}
              : mem_funct3_q == 3'b001 ? {{(DATA_WIDTH-16){half_sh[15]}}, half_sh[15:0]}
              : mem_funct3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_sh[15:0]}
              : bus.dmem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {mem_valid, mem_reg_write_q, mem_read_q, mem_write_q, mem_funct3_q, mem_rd_q} <= '0;
      {mem_alu_q, mem_store_q} <= '0;
      {wb_valid, wb_reg_write_q, wb_rd_q, wb_data_q} <= '0;
    end else if (stall) begin
      wb_valid <= 1'b0;
    end else begin
      mem_valid       <= bus.ex_valid;
      mem_reg_write_q <= bus.ex_regWrite;
      mem_read_q      <= bus.ex_memRead;
      mem_write_q     <= bus.ex_memWrite;
      mem_funct3_q    <= bus.ex_funct3;
      mem_rd_q        <= bus.ex_rd;
      mem_alu_q       <= bus.ex_alu_result;
      mem_store_q     <= bus.ex_store_data;
      wb_valid        <= mem_valid;
      wb_reg_write_q  <= mem_reg_write_q;
      wb_rd_q         <= mem_rd_q;
      wb_data_q       <= mem_read_q ? load_data : mem_alu_q;
    end
  end
  assign bus.pipe_stall     = stall;
  assign bus.mem_regWrite   = mem_valid & mem_reg_write_q & (mem_rd_q != 5'd0);
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_alu_result = mem_alu_q;
  assign bus.mem_memRead    = mem_valid & mem_read_q;
  assign bus.mem_memWrite   = mem_valid & mem_write_q;
  assign bus.mem_funct3     = mem_funct3_q;
  assign bus.mem_store_data = mem_store_q;
  assign bus.wb_regWrite    = wb_valid & wb_reg_write_q & (wb_rd_q != 5'd0);
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: directed load-extension table, multi-cycle stall/reset sequences, random run vs reference model
module tb_ex_mem_wb_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ex_mem_wb_pipe_if bus();
  ex_mem_wb_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic v, rw, mr, mw;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] alu, sd;
  } mem_t;
  typedef struct packed {
    logic v, rw;
    logic [4:0] rd;
    logic [31:0] d;
  } wb_t;
  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;
  mem_t m = '0;
  wb_t  w = '0;
  ld_vec_t lv[6];
  function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned b, h;
    b = (wd >> (8 * addr[1:0])) & 32'hFF;
    h = (wd >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b >= 128 ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return h >= 32768 ? h - 65536 : h;
      3'b101:  return h;
      default: return wd;
    endcase
  endfunction
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_ex(input logic v, rw, mr, mw, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, sd);
    bus.ex_valid = v; bus.ex_regWrite = rw; bus.ex_memRead = mr; bus.ex_memWrite = mw;
    bus.ex_funct3 = f3; bus.ex_rd = rd; bus.ex_alu_result = alu; bus.ex_store_data = sd;
  endtask
  task automatic bubble();
    set_ex(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
  endtask
  task automatic model_check();
    logic s;
    s = m.v && (m.mr || m.mw) && !bus.dmem_ready;
    chk("model_stall", 80'(bus.pipe_stall), 80'(s));
    chk("model_mem",
        80'({bus.mem_regWrite, bus.mem_rd, bus.mem_alu_result, bus.mem_memRead, bus.mem_memWrite,
             bus.mem_funct3, bus.mem_store_data}),
        80'({m.v & m.rw & (m.rd != 0), m.rd, m.alu, m.v & m.mr, m.v & m.mw, m.f3, m.sd}));
    chk("model_wb_we", 80'(bus.wb_regWrite), 80'(w.v & w.rw & (w.rd != 0)));
    if (w.v) chk("model_wb_data", 80'({bus.wb_rd, bus.wb_data}), 80'({w.rd, w.d}));
  endtask
  task automatic model_step();
    if (rst) begin
      m = '0;
      w = '0;
    end else if (m.v && (m.mr || m.mw) && !bus.dmem_ready) begin
      w.v = 1'b0;
    end else begin
      w = '{m.v, m.rw, m.rd, m.mr ? ext_ref(m.f3, m.alu, bus.dmem_rdata) : m.alu};
      m = '{bus.ex_valid, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.ex_funct3,
            bus.ex_rd, bus.ex_alu_result, bus.ex_store_data};
    end
  endtask
  task automatic cycle(input bit do_check);
    @(negedge clk);
    if (do_check) model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask
  initial begin
    lv[0] = '{"lb",   3'b000, 32'h103, 32'hFFFFFF80};
    lv[1] = '{"lbu",  3'b100, 32'h103, 32'h00000080};
    lv[2] = '{"lh",   3'b001, 32'h102, 32'hFFFF80FF};
    lv[3] = '{"lhu",  3'b101, 32'h102, 32'h000080FF};
    lv[4] = '{"lw",   3'b010, 32'h100, 32'h80FF1234};
    lv[5] = '{"lh_a0", 3'b001, 32'h101, 32'h00001234};
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'h80FF1234;
    set_ex(1, 1, 0, 0, 3'd0, 5'd7, 32'h1234, 32'h0);
    rst = 1'b1;
    cycle(0);
    cycle(1);
    #1;
    chk("reset_outputs",
        80'({bus.mem_regWrite, bus.mem_rd, bus.mem_alu_result, bus.mem_memRead, bus.mem_memWrite,
             bus.mem_funct3, bus.wb_regWrite, bus.wb_rd}), 80'd0);
    chk("reset_wb_data", 80'({bus.wb_data, bus.mem_store_data}), 80'd0);
    chk("reset_stall", 80'(bus.pipe_stall), 80'd0);
    rst = 1'b0;
    set_ex(1, 1, 0, 0, 3'b000, 5'd5, 32'hDEADBEEF, 32'h0);
    cycle(1);
    bubble();
    #1;
    chk("alu_mem", 80'({bus.mem_regWrite, bus.mem_rd}), 80'({1'b1, 5'd5}));
    cycle(1);
    #1;
    chk("alu_wb", 80'({bus.wb_regWrite, bus.wb_rd, bus.wb_data}), 80'({1'b1, 5'd5, 32'hDEADBEEF}));
    foreach (lv[i]) begin
      set_ex(1, 1, 1, 0, lv[i].f3, 5'd10, lv[i].addr, 32'h0);
      cycle(1);
      bubble();
      cycle(1);
      #1;
      chk(lv[i].name, 80'({bus.wb_regWrite, bus.wb_data}), 80'({1'b1, lv[i].exp}));
    end
    set_ex(1, 1, 1, 0, 3'b010, 5'd9, 32'h200, 32'h0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'hCAFEF00D;
    cycle(1);
    set_ex(1, 1, 0, 0, 3'b000, 5'd4, 32'h44, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_hold", 80'({bus.pipe_stall, bus.mem_rd, bus.wb_regWrite}), 80'({1'b1, 5'd9, 1'b0}));
      cycle(1);
    end
    bus.dmem_ready = 1'b1;
    #1;
    chk("ready_no_stall", 80'(bus.pipe_stall), 80'd0);
    cycle(1);
    bubble();
    #1;
    chk("after_ready", 80'({bus.wb_regWrite, bus.wb_rd, bus.wb_data, bus.mem_rd}),
        80'({1'b1, 5'd9, 32'hCAFEF00D, 5'd4}));
    set_ex(1, 1, 0, 0, 3'b000, 5'd0, 32'h55, 32'h0);
    cycle(1);
    bubble();
    #1;
    chk("x0_mem_we", 80'(bus.mem_regWrite), 80'd0);
    cycle(1);
    #1;
    chk("x0_wb_we", 80'(bus.wb_regWrite), 80'd0);
    set_ex(1, 0, 0, 1, 3'b010, 5'd3, 32'h300, 32'h12345678);
    bus.dmem_ready = 1'b0;
    cycle(1);
    bubble();
    #1;
    chk("store_stall", 80'({bus.pipe_stall, bus.mem_memWrite}), 80'({1'b1, 1'b1}));
    cycle(1);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    #1;
    chk("rst_in_stall", 80'({bus.pipe_stall, bus.mem_memWrite, bus.mem_regWrite, bus.mem_rd,
                              bus.mem_alu_result, bus.wb_regWrite, bus.wb_rd}), 80'd0);
    chk("rst_in_stall_data", 80'({bus.mem_store_data, bus.wb_data}), 80'd0);
    bus.dmem_ready = 1'b1;
    for (int k = 0; k < 600; k++) begin
      int op;
      op = $urandom_range(0, 2);
      set_ex($urandom_range(0, 3) != 0, op != 2, op == 1, op == 2, 3'($urandom),
             5'($urandom), $urandom, $urandom);
      bus.dmem_ready = $urandom_range(0, 9) < 6;
      bus.dmem_rdata = $urandom;
      rst = $urandom_range(0, 49) == 0;
      cycle(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
